// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debounce controller and its event FIFO.
// Provides the scanner state enum, the event payload struct, a width helper
// that never returns zero, and the clock-to-tick divider helper.
package debounce_pkg;

    // Event channel field is sized for the largest supported channel count (16).
    localparam int unsigned EVT_CH_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [EVT_CH_W-1:0] ch;
        logic                press;
    } debounce_evt_t;

    // Bit width able to hold 0..v-1, never less than one bit.
    function automatic int unsigned safe_clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Number of clk cycles per scan tick.
    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned sample_hz);
        return clk_hz / sample_hz;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO of debounce events, pointer-plus-count organisation.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request and payload; ignored while full unless
//                     a pop happens in the same cycle
//   full            : no free entry
//   pop             : remove head; ignored while empty
//   empty           : no entry stored
//   head            : oldest entry (stable until popped)
module event_fifo
    import debounce_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  debounce_evt_t push_data,
    output logic          full,
    input  logic          pop,
    output logic          empty,
    output debounce_evt_t head
);

    localparam int unsigned PTR_W = safe_clog2(DEPTH);
    localparam int unsigned CNT_W = safe_clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("event_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    debounce_evt_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop_c;
    logic             do_push_c;

    // A pop frees the slot the same cycle, so a full FIFO can still accept.
    assign do_pop_c  = pop && (count != '0);
    assign do_push_c = push && ((count != CNT_W'(DEPTH)) || do_pop_c);

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/button_scan_ctrl.sv
// Multi-channel debounce controller: synchronises raw inputs, scans one
// integrator per channel on a shared low-rate tick and reports every debounced
// level change as a press/release event through a small buffered stream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_raw     : asynchronous raw inputs, 1 = pressed
//   level      : debounced levels
//   evt_valid  : event available at buffer head
//   evt_ready  : consumer accepts the head when evt_valid & evt_ready
//   evt_ch     : channel of the head event
//   evt_press  : 1 = press (0->1), 0 = release (1->0)
//   overflow   : sticky, set when an event is dropped on a full buffer
//   clear_ovf  : clears overflow next cycle; a simultaneous set wins
module button_scan_ctrl
    import debounce_pkg::*;
#(
    parameter  int unsigned N_CH       = 4,
    parameter  int unsigned CLK_HZ     = 16000000,
    parameter  int unsigned SAMPLE_HZ  = 1000,
    parameter  int unsigned STABLE_CNT = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CH_W       = safe_clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in_raw,
    output logic [N_CH-1:0] level,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_press,
    output logic            overflow,
    input  logic            clear_ovf
);

    localparam int unsigned DIV   = tick_div(CLK_HZ, SAMPLE_HZ);
    localparam int unsigned DIV_W = safe_clog2(DIV);
    localparam int unsigned CNT_W = safe_clog2(STABLE_CNT);

    generate
        if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
            $error("button_scan_ctrl: N_CH must be 1..16");
        end
        if (STABLE_CNT < 2 || STABLE_CNT > 255) begin : g_bad_stable
            $error("button_scan_ctrl: STABLE_CNT must be 2..255");
        end
        // A full scan plus the return to IDLE must fit between two ticks.
        if (DIV < N_CH + 2) begin : g_bad_rate
            $error("button_scan_ctrl: CLK_HZ/SAMPLE_HZ must be >= N_CH+2");
        end
    endgenerate

    logic [N_CH-1:0]            sync_meta;
    logic [N_CH-1:0]            sync_q;
    logic [DIV_W-1:0]           presc;
    logic                       tick_c;
    scan_state_t                state;
    logic [CH_W-1:0]            ch;
    logic [N_CH-1:0][CNT_W-1:0] cnt;

    logic                       cur_sync_c;
    logic                       cur_level_c;
    logic [CNT_W-1:0]           cur_cnt_c;
    logic                       flip_c;
    logic                       drop_c;
    debounce_evt_t              push_evt_c;
    debounce_evt_t              head;
    logic                       fifo_full;
    logic                       fifo_empty;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= in_raw;
            sync_q    <= sync_meta;
        end
    end

    // Tick prescaler: tick is high for the single cycle at terminal count.
    assign tick_c = (presc == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (tick_c) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_W'(1);
        end
    end

    // View of the channel currently being scanned.
    assign cur_sync_c  = sync_q[ch];
    assign cur_level_c = level[ch];
    assign cur_cnt_c   = cnt[ch];
    assign flip_c      = (state == SCAN) && (cur_sync_c != cur_level_c)
                         && (cur_cnt_c == CNT_W'(STABLE_CNT - 1));
    assign push_evt_c  = '{ch: EVT_CH_W'(ch), press: ~cur_level_c};

    // Scanner FSM and per-channel integrators; one channel handled per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            cnt   <= '0;
            level <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick_c) begin
                        state <= SCAN;
                        ch    <= '0;
                    end
                end
                SCAN: begin
                    // Any agreeing sample restarts the stability count.
                    if (cur_sync_c == cur_level_c) begin
                        cnt[ch] <= '0;
                    end else if (cur_cnt_c == CNT_W'(STABLE_CNT - 1)) begin
                        level[ch] <= ~cur_level_c;
                        cnt[ch]   <= '0;
                    end else begin
                        cnt[ch] <= cur_cnt_c + CNT_W'(1);
                    end

                    if (ch == CH_W'(N_CH - 1)) begin
                        state <= IDLE;
                        ch    <= '0;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ch    <= '0;
                end
            endcase
        end
    end

    // A full buffer still accepts when the consumer pops in the same cycle.
    assign drop_c = flip_c && fifo_full && !evt_ready;

    // Sticky overflow flag; a new drop takes priority over the clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_event_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (flip_c),
        .push_data (push_evt_c),
        .full      (fifo_full),
        .pop       (evt_ready),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_ch    = CH_W'(head.ch);
    assign evt_press = head.press;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Self-checking bench for button_scan_ctrl: directed scenarios followed by
// randomized pins/ready/clear, checked against a run-length debounce model
// with a bounded-capacity event queue.
module tb_button_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 10;
    localparam int STBL  = 3;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_raw;
    logic [3:0] level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_press;
    logic       overflow;
    logic       clear_ovf;

    always #5 clk = ~clk;

    button_scan_ctrl #(
        .N_CH       (N),
        .CLK_HZ     (100),
        .SAMPLE_HZ  (10),
        .STABLE_CNT (STBL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_raw    (in_raw),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_press (evt_press),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    typedef struct {
        int ch;
        bit press;
    } exp_evt_t;

    exp_evt_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    bit       armed = 1'b0;
    int       m_phase;
    bit       m_scan;
    int       m_idx;
    bit [3:0] m_samp;
    bit [3:0] m_lvl;
    int       m_run [N];
    int       m_occ;
    bit       m_ovf;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level flips after STBL consecutive disagreeing scan samples;
    // channel i is judged i+1 cycles after the tick; events go to a queue
    // of DEPTH entries that frees a slot in the same cycle the consumer pops.
    always @(posedge clk) begin
        bit pop;
        bit push;
        bit drop;
        int pch;
        bit pval;
        if (rst) begin
            armed   = 1'b1;
            m_phase = 0;
            m_scan  = 1'b0;
            m_idx   = 0;
            m_samp  = '0;
            m_lvl   = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_occ   = 0;
            m_ovf   = 1'b0;
            exp_q.delete();
        end else if (armed) begin
            pop  = evt_ready && (m_occ > 0);
            push = 1'b0;
            drop = 1'b0;
            pch  = 0;
            pval = 1'b0;
            if (m_scan) begin
                if (m_samp[m_idx] != m_lvl[m_idx]) begin
                    m_run[m_idx] = m_run[m_idx] + 1;
                    if (m_run[m_idx] == STBL) begin
                        m_lvl[m_idx] = ~m_lvl[m_idx];
                        m_run[m_idx] = 0;
                        push = 1'b1;
                        pch  = m_idx;
                        pval = m_lvl[m_idx];
                    end
                end else begin
                    m_run[m_idx] = 0;
                end
                m_idx = m_idx + 1;
                if (m_idx == N) m_scan = 1'b0;
            end
            if (m_phase == DIV - 1) begin
                m_scan  = 1'b1;
                m_idx   = 0;
                m_samp  = in_raw;
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
            if (push) begin
                if (m_occ < DEPTH || pop) begin
                    exp_q.push_back('{pch, pval});
                    m_occ = m_occ + 1;
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (pop) m_occ = m_occ - 1;
        end
    end

    // Monitor: compares outputs mid-cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        exp_evt_t e;
        if (armed) begin
            check("level", int'(level), int'(m_lvl));
            check("overflow", int'(overflow), int'(m_ovf));
            check("evt_valid", int'(evt_valid), int'(exp_q.size() > 0));
            if (evt_valid && evt_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_ch", int'(evt_ch), e.ch);
                    check("evt_press", int'(evt_press), int'(e.press));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance to a cycle whose prescaler value is p.
    task automatic to_phase(input int p);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (m_phase != p && guard < 50);
        if (guard >= 50) check("phase_timeout", guard, 0);
    endtask

    // Change the pins away from any scan window, then hold for n ticks.
    task automatic apply(input logic [3:0] v, input int n);
        to_phase(5);
        in_raw = v;
        repeat (n) to_phase(5);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst       = 1'b1;
        in_raw    = '0;
        evt_ready = 1'b0;
        clear_ovf = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Clean press on channel 2
        evt_ready = 1'b1;
        apply(4'b0100, 5);

        // Bounce on channel 1: agrees with level every second tick
        for (int k = 0; k < 10; k++) apply((k % 2 == 0) ? 4'b0110 : 4'b0100, 1);

        // Release channel 2, then simultaneous press on all channels with no consumer
        apply(4'b0000, 5);
        evt_ready = 1'b0;
        apply(4'b1111, 5);

        // Release everything while the buffer is full: all four events dropped
        apply(4'b0000, 5);
        step();
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        repeat (3) step();

        // Drain the four queued presses back to back
        evt_ready = 1'b1;
        repeat (8) step();

        // Refill with presses, then a release whose first push meets a pop
        evt_ready = 1'b0;
        apply(4'b1111, 5);
        apply(4'b0000, 2);
        to_phase(0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        repeat (5) step();
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        evt_ready = 1'b1;
        repeat (10) step();

        // Two queued events and level 0101, then reset two cycles after a tick
        evt_ready = 1'b0;
        apply(4'b0101, 4);
        to_phase(1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (40) step();

        // Randomized pins, consumer and clear requests
        for (int c = 0; c < 600; c++) begin
            step();
            evt_ready = ($urandom_range(3) != 0);
            clear_ovf = ($urandom_range(15) == 0);
            if (m_phase == 5 && $urandom_range(2) == 0) in_raw = 4'($urandom);
        end

        // Drain remaining events
        evt_ready = 1'b1;
        clear_ovf = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || evt_valid) && guard < 200) begin
            step();
            guard++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", int'(evt_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_scan_ctrl.md
# button_scan_ctrl

Multi-channel debounce controller. It samples N raw button/switch inputs on a shared low-rate tick and scans them through one integrator per channel. Each change of a debounced level is reported as a press or release event through a small buffered valid/ready event stream. It sits between the board pins and the host-visible register/interrupt logic, replacing per-pin free-running shift-register debouncers with one shared scheduler.

## Interface
Parameters:
- `N_CH`, 4: number of input channels (1..16).
- `CLK_HZ`, 16000000: `clk` frequency.
- `SAMPLE_HZ`, 1000: scan tick rate. Elaboration error unless `CLK_HZ/SAMPLE_HZ >= N_CH+2`.
- `STABLE_CNT`, 8: consecutive differing samples required to flip a level (2..255).
- `FIFO_DEPTH`, 4: event buffer entries, a power of two ≥ 2.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `in_raw` in N_CH: asynchronous raw inputs, 1 = pressed.
- `level` out N_CH: debounced levels.
- `evt_valid` out 1: event available at FIFO head.
- `evt_ready` in 1: consumer accepts the head when `evt_valid & evt_ready`.
- `evt_ch` out clog2(N_CH) (min 1): channel of the head event.
- `evt_press` out 1: 1 = 0→1 transition, 0 = 1→0 transition.
- `overflow` out 1: sticky flag, set when an event is dropped because the FIFO is full.
- `clear_ovf` in 1: clears `overflow` in the next cycle; a set in the same cycle wins.

## Operation
- **Input sync:** each `in_raw` bit passes through a 2-flop synchronizer, giving `sync[i]`.
- **Prescaler:** counter 0..`CLK_HZ/SAMPLE_HZ`-1. `tick` pulses for one cycle at the terminal count, then the counter wraps to 0.
- **Scanner FSM:**
  - IDLE: on `tick` → SCAN with `ch`=0.
  - SCAN: processes channel `ch` each cycle. When `ch`=N_CH-1 → IDLE, otherwise `ch`+1.
  - A tick cannot arrive during SCAN; the parameter check guarantees this.
- **Integrator:** per channel, `cnt[i]` is clog2(STABLE_CNT) bits. When channel i is processed:
  - `sync[i]==level[i]` → `cnt[i]`=0.
  - Else if `cnt[i]==STABLE_CNT-1` → `level[i]` toggles, `cnt[i]`=0, push {ch=i, press=new level}.
  - Else `cnt[i]`+1.
  - A single agreeing sample resets the count. No saturation or wrap is possible.
- **FIFO push/pop:**
  - Push attempt while full, with no pop that cycle → event dropped, `overflow`←1. `level` still toggles.
  - Push and pop in the same cycle while full → both occur, nothing is dropped.
  - Pop while empty → ignored.
- **Event ordering:** strictly by scan order, so within one scan lower channel numbers come first.
- **Reset:** while `rst`=1, every state element clears on each clock edge, whether or not a scan is in progress:
  - synchronizers, `cnt`, `level`=0, prescaler=0, FSM=IDLE, `ch`=0
  - FIFO empty, `evt_valid`=0, `evt_ch`=0, `evt_press`=0, `overflow`=0.
  - Inputs already high at reset release produce a press event after debounce.

## Timing
- **Pin to level:** sync latency is 2 cycles. A clean edge needs `STABLE_CNT` consecutive tick-scans with disagreement.
  - `level[i]` updates 1 cycle after the cycle in which channel i is processed.
  - That cycle is `tick`+1+i.
  - Worst case edge→level = `STABLE_CNT × CLK_HZ/SAMPLE_HZ` + `N_CH` + 4 cycles.
- **Event:** `evt_valid` rises in the same cycle `level` changes, if the FIFO was empty.
- **Head stability:** `evt_ch`/`evt_press` are stable while `evt_valid & !evt_ready`.
- **Dependencies:** no combinational path from `evt_ready` to `evt_valid`, or from `in_raw` to any output.
- **Throughput:** ≤ 1 push per cycle, 1 pop per cycle. A full FIFO with `evt_ready` held high drops nothing.

## Structure
- **Package `debounce_pkg`:**
  - `scan_state_t` enum {IDLE, SCAN}
  - `debounce_evt_t` struct {ch, press}
  - `clog2`-safe width function
  - localparam helper for `CLK_HZ/SAMPLE_HZ`.
- **Sub-module `event_fifo`:**
  - Synchronous FIFO of `debounce_evt_t`.
  - Ports: push/full, pop/empty, head.
  - Pointer-plus-count implementation.
  - Reusable by other event sources.
- **Top level:** synchronizers, prescaler, FSM and integrators stay in the top level.

## Test plan
Bench parameters: `CLK_HZ`=100, `SAMPLE_HZ`=10 (tick every 10 cycles), `N_CH`=4, `STABLE_CNT`=3, `FIFO_DEPTH`=4.
- **Clean press:**
  - Stimulus: `in_raw[2]`: 0→1 held, `evt_ready`=1.
  - Response: `level[2]`=1 after exactly 3 scans, one event {ch=2, press=1}, then nothing more.
- **Bounce rejection:**
  - Stimulus: `in_raw[1]` toggles, agreeing with `level` every 2nd tick, for 10 ticks.
  - Response: `level[1]` stays 0, no events.
- **Simultaneous edges:**
  - Stimulus: `in_raw`=4'b1111 at once, `evt_ready`=0.
  - Response: 4 events queued in order ch 0,1,2,3, all press=1, `overflow`=0. Release `evt_ready`: 4 pops on 4 consecutive cycles.
- **Overflow:**
  - Stimulus: from the previous state, `in_raw`=0 with `evt_ready`=0.
  - Response: 4 release events dropped, `level`=0, `overflow`=1.
  - Then `clear_ovf` pulse → `overflow`=0 the next cycle, queued press events intact.
- **Full push+pop:**
  - Stimulus: FIFO full, `evt_ready`=1 in the cycle a new event is pushed.
  - Response: no drop, count stays 4.
- **Reset mid-scan:**
  - Stimulus: assert `rst` 2 cycles after a `tick`, with `level`=4'b0101 and 2 events queued.
  - Response: next cycle all outputs 0, FIFO empty. After release, the first tick arrives 10 cycles later.
